// File: rtl/kairo_dbgbus_master_if.sv
// Debug command/response, main-master status and debug bus signals for kairo_dbgbus_master.
interface kairo_dbgbus_master_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_WRITE;
  logic [3:0]  CMD_WSTB;
  logic [31:0] CMD_ADDR;
  logic [31:0] CMD_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_STATUS;
  logic        M_BUSY;
  logic        SELECT;
  logic        D_VALID;
  logic [3:0]  D_WSTB;
  logic [31:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic        D_READY;
  logic [31:0] D_RDATA;
  logic        D_EXCEPT;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_WSTB, CMD_ADDR, CMD_WDATA, RSP_READY,
           M_BUSY, D_READY, D_RDATA, D_EXCEPT,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_STATUS, SELECT,
           D_VALID, D_WSTB, D_ADDR, D_WDATA
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_WSTB, CMD_ADDR, CMD_WDATA, RSP_READY,
           M_BUSY, D_READY, D_RDATA, D_EXCEPT,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_STATUS, SELECT,
           D_VALID, D_WSTB, D_ADDR, D_WDATA
  );
endinterface

// File: rtl/kairo_dbgbus_master.sv
// Debug bus master: takes one debug command, acquires the shared bus once the main
// master is idle, runs a single D_* transaction with timeout and returns data/status.
module kairo_dbgbus_master #(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  kairo_dbgbus_master_if.master  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;
  localparam logic [1:0] S_RSP  = 2'd3;

  localparam bit                   TO_EN   = (TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [1:0]           state_q,  state_d;
  logic                 write_q,  write_d;
  logic [3:0]           wstb_q,   wstb_d;
  logic [31:0]          addr_q,   addr_d;
  logic [31:0]          wdata_q,  wdata_d;
  logic [31:0]          rdata_q,  rdata_d;
  logic [1:0]           status_q, status_d;
  logic                 select_q, select_d;
  logic [TIMEOUT_W-1:0] cnt_q,    cnt_d;

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    wstb_d   = wstb_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    select_d = select_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.CMD_VALID) begin
          write_d = bus.CMD_WRITE;
          wstb_d  = bus.CMD_WRITE ? bus.CMD_WSTB : 4'b0000;
          addr_d  = bus.CMD_ADDR;
          wdata_d = bus.CMD_WDATA;
          state_d = S_ACQ;
        end
      end
      S_ACQ: begin
        // Only take the bus once the main master has no transfer outstanding.
        if (!bus.M_BUSY) begin
          select_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        // D_READY is checked first so it wins over a simultaneous timeout.
        if (bus.D_READY) begin
          rdata_d  = write_q ? '0 : bus.D_RDATA;
          status_d = bus.D_EXCEPT ? 2'b01 : 2'b00;
          select_d = 1'b0;
          state_d  = S_RSP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          rdata_d  = '0;
          status_d = 2'b10;
          select_d = 1'b0;
          state_d  = S_RSP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      S_RSP: begin
        if (bus.RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      wstb_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      status_q <= '0;
      select_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      wstb_q   <= wstb_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      select_q <= select_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.CMD_READY  = (state_q == S_IDLE);
  assign bus.RSP_VALID  = (state_q == S_RSP);
  assign bus.D_VALID    = (state_q == S_REQ);
  assign bus.SELECT     = select_q;
  assign bus.D_WSTB     = wstb_q;
  assign bus.D_ADDR     = addr_q;
  assign bus.D_WDATA    = wdata_q;
  assign bus.RSP_RDATA  = rdata_q;
  assign bus.RSP_STATUS = status_q;

endmodule

// File: tb/tb_kairo_dbgbus_master.sv
// Bench for kairo_dbgbus_master: default-timeout instance A and TIMEOUT=4 instance B,
// driven from a vector table with a response scoreboard.
module tb_kairo_dbgbus_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        which = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [3:0]  cmd_wstb = '0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_ready = 1'b0, m_busy = 1'b0, d_ready = 1'b0, d_except = 1'b0;
  logic [31:0] d_rdata = '0;

  kairo_dbgbus_master_if ifa ();
  kairo_dbgbus_master_if ifb ();

  assign ifa.CMD_VALID = !which && cmd_valid;
  assign ifb.CMD_VALID =  which && cmd_valid;
  assign ifa.RSP_READY = !which && rsp_ready;
  assign ifb.RSP_READY =  which && rsp_ready;
  assign ifa.M_BUSY    = !which && m_busy;
  assign ifb.M_BUSY    =  which && m_busy;
  assign ifa.D_READY   = !which && d_ready;
  assign ifb.D_READY   =  which && d_ready;
  assign ifa.CMD_WRITE = cmd_write;  assign ifb.CMD_WRITE = cmd_write;
  assign ifa.CMD_WSTB  = cmd_wstb;   assign ifb.CMD_WSTB  = cmd_wstb;
  assign ifa.CMD_ADDR  = cmd_addr;   assign ifb.CMD_ADDR  = cmd_addr;
  assign ifa.CMD_WDATA = cmd_wdata;  assign ifb.CMD_WDATA = cmd_wdata;
  assign ifa.D_RDATA   = d_rdata;    assign ifb.D_RDATA   = d_rdata;
  assign ifa.D_EXCEPT  = d_except;   assign ifb.D_EXCEPT  = d_except;

  kairo_dbgbus_master #(.TIMEOUT_W(8), .TIMEOUT(255)) dut_a (.CLK(clk), .RST_N(rst_n), .bus(ifa));
  kairo_dbgbus_master #(.TIMEOUT_W(8), .TIMEOUT(4))   dut_b (.CLK(clk), .RST_N(rst_n), .bus(ifb));

  logic        o_cmd_ready, o_rsp_valid, o_select, o_d_valid;
  logic [31:0] o_rsp_rdata, o_d_addr, o_d_wdata;
  logic [1:0]  o_rsp_status;
  logic [3:0]  o_d_wstb;
  assign o_cmd_ready  = which ? ifb.CMD_READY  : ifa.CMD_READY;
  assign o_rsp_valid  = which ? ifb.RSP_VALID  : ifa.RSP_VALID;
  assign o_select     = which ? ifb.SELECT     : ifa.SELECT;
  assign o_d_valid    = which ? ifb.D_VALID    : ifa.D_VALID;
  assign o_rsp_rdata  = which ? ifb.RSP_RDATA  : ifa.RSP_RDATA;
  assign o_rsp_status = which ? ifb.RSP_STATUS : ifa.RSP_STATUS;
  assign o_d_addr     = which ? ifb.D_ADDR     : ifa.D_ADDR;
  assign o_d_wdata    = which ? ifb.D_WDATA    : ifa.D_WDATA;
  assign o_d_wstb     = which ? ifb.D_WSTB     : ifa.D_WSTB;

  typedef struct {
    logic        which;
    logic        write;
    logic [3:0]  wstb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          mbusy;      // cycles M_BUSY stays high after accept
    int          delay;      // REQ cycle (0-based) in which D_READY is given; 255 = never
    logic        except;
    logic [31:0] rdata;
    int          hold;       // cycles RSP_READY stays low
    logic        pend;       // present next vector's command during the hold
    logic [31:0] exp_rdata;
    logic [1:0]  exp_status;
    int          exp_lat;    // accept edge to first RSP_VALID cycle
    int          exp_dv;     // D_VALID-high cycles
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  status;
  } exp_t;

  vec_t vec[9];
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (rst_n && o_rsp_valid && rsp_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_rsp: got a response expected none");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_rdata", o_rsp_rdata, e.rdata);
        chk("sb_status", 32'(o_rsp_status), 32'(e.status));
      end
    end
  end

  task automatic run_vec(input int idx);
    vec_t v;
    vec_t nx;
    int waits, req_cnt, rsp_cyc;
    string tag;
    v = vec[idx];
    tag = $sformatf("v%0d", idx);
    which     = v.which;
    cmd_write = v.write;
    cmd_wstb  = v.wstb;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    d_rdata   = v.rdata;
    d_except  = v.except;
    cmd_valid = 1'b1;
    waits = 0;
    while (!o_cmd_ready && waits < 50) begin
      tick();
      waits++;
    end
    chk({tag, "_accept_wait"}, 32'(waits < 50), 32'd1);
    sbq.push_back('{rdata: v.exp_rdata, status: v.exp_status});
    tick();
    cmd_valid = 1'b0;
    req_cnt = 0;
    rsp_cyc = -1;
    for (int c = 1; c < 300; c++) begin
      m_busy = (c <= v.mbusy);
      if (o_rsp_valid) begin
        rsp_cyc = c;
        d_ready = 1'b0;
        break;
      end
      chk({tag, "_select_eq_dvalid"}, 32'(o_select), 32'(o_d_valid));
      if (o_d_valid) begin
        chk({tag, "_d_addr"}, o_d_addr, v.addr);
        chk({tag, "_d_wdata"}, o_d_wdata, v.wdata);
        chk({tag, "_d_wstb"}, 32'(o_d_wstb), v.write ? 32'(v.wstb) : 32'd0);
        d_ready = (req_cnt == v.delay);
        req_cnt++;
      end else begin
        d_ready = 1'b0;
      end
      tick();
    end
    m_busy = 1'b0;
    chk({tag, "_latency"}, 32'(rsp_cyc), 32'(v.exp_lat));
    chk({tag, "_dvalid_cycles"}, 32'(req_cnt), 32'(v.exp_dv));
    chk({tag, "_rsp_select"}, 32'(o_select), 32'd0);
    if (v.pend) begin
      nx = vec[idx + 1];
      cmd_write = nx.write;
      cmd_wstb  = nx.wstb;
      cmd_addr  = nx.addr;
      cmd_wdata = nx.wdata;
      cmd_valid = 1'b1;
    end
    for (int h = 0; h < v.hold; h++) begin
      chk({tag, "_hold_valid"}, 32'(o_rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, o_rsp_rdata, v.exp_rdata);
      chk({tag, "_hold_status"}, 32'(o_rsp_status), 32'(v.exp_status));
      chk({tag, "_hold_cmd_ready"}, 32'(o_cmd_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_post_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
    chk({tag, "_post_cmd_ready"}, 32'(o_cmd_ready), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(o_cmd_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
    chk({tag, "_select"}, 32'(o_select), 32'd0);
    chk({tag, "_d_valid"}, 32'(o_d_valid), 32'd0);
  endtask

  initial begin
    int waits;
    //          which write wstb  addr          wdata         mb dly ex rdata         hold pend exp_rdata     st    lat dv
    vec[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_1000, 32'h0,        0, 0,  1'b0, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF, 2'b00, 3, 1};
    vec[1] = '{1'b0, 1'b1, 4'h3, 32'h0000_0020, 32'h1234_5678, 0, 4,  1'b1, 32'hFFFF_FFFF, 0, 1'b0, 32'h0,         2'b01, 7, 5};
    vec[2] = '{1'b0, 1'b0, 4'h0, 32'h0000_0044, 32'h0,        6, 1,  1'b0, 32'h0BAD_F00D, 0, 1'b0, 32'h0BAD_F00D, 2'b00, 10, 2};
    vec[3] = '{1'b1, 1'b0, 4'h0, 32'h0000_0080, 32'h0,        0, 255,1'b0, 32'h7777_7777, 0, 1'b0, 32'h0,         2'b10, 6, 4};
    vec[4] = '{1'b1, 1'b0, 4'h0, 32'h0000_0084, 32'h0,        0, 3,  1'b0, 32'hA5A5_0001, 0, 1'b0, 32'hA5A5_0001, 2'b00, 6, 4};
    vec[5] = '{1'b1, 1'b1, 4'hC, 32'h0000_0088, 32'h8765_4321, 0, 2,  1'b1, 32'h1111_1111, 0, 1'b0, 32'h0,         2'b01, 5, 3};
    vec[6] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,        0, 0,  1'b0, 32'h1111_2222, 5, 1'b1, 32'h1111_2222, 2'b00, 3, 1};
    vec[7] = '{1'b0, 1'b1, 4'hF, 32'h0000_0104, 32'hCAFE_0001, 0, 0,  1'b0, 32'h3333_4444, 0, 1'b0, 32'h0,         2'b00, 3, 1};
    vec[8] = '{1'b0, 1'b0, 4'h0, 32'h0000_0300, 32'h0,        0, 1,  1'b0, 32'h55AA_55AA, 0, 1'b0, 32'h55AA_55AA, 2'b00, 4, 2};

    tick();
    tick();
    which = 1'b0;
    #1;
    chk_reset_vals("rst_a");
    chk("rst_a_d_addr", o_d_addr, 32'h0);
    chk("rst_a_d_wstb", 32'(o_d_wstb), 32'h0);
    chk("rst_a_rsp_rdata", o_rsp_rdata, 32'h0);
    chk("rst_a_rsp_status", 32'(o_rsp_status), 32'h0);
    which = 1'b1;
    #1;
    chk_reset_vals("rst_b");
    chk("rst_b_d_wdata", o_d_wdata, 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset pulse while instance A sits in REQ with no D_READY.
    which     = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0200;
    cmd_valid = 1'b1;
    waits = 0;
    while (!o_cmd_ready && waits < 50) begin
      tick();
      waits++;
    end
    sbq.push_back('{rdata: 32'h0, status: 2'b00});
    tick();
    cmd_valid = 1'b0;
    waits = 0;
    while (!o_d_valid && waits < 20) begin
      tick();
      waits++;
    end
    chk("midrst_reached_req", 32'(o_d_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    void'(sbq.pop_back());
    tick();
    rst_n = 1'b1;
    tick();
    run_vec(8);

    tick();
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
